// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-address sequencer for an in-order front end. It produces the next
// instruction address every cycle and handles:
//   * a one-cycle BOOT state after reset release,
//   * sequential fetch with stall hold,
//   * taken-branch redirects with a FLUSH_CYC-cycle fetch bubble and a
//     one-cycle squash pulse,
//   * call/return link prediction through a return-address stack.
//
// Build option (macro PC_SEQ_RAS_EN):
//   defined   : RAS_DEPTH-entry circular return-address stack with a sticky
//               overflow flag.
//   undefined : a single link register replaces the stack; ras_ovf_o is 0.
//
// Parameters:
//   ADDR_W    instruction address width
//   RESET_PC  first fetch address after reset
//   FLUSH_CYC bubble cycles after a redirect (1..3)
//   RAS_DEPTH return-address-stack entries (power of two, >= 2)
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   stall_i       hold the PC (downstream not ready)
//   br_valid_i    branch resolution presented this cycle
//   br_taken_i    branch decision
//   br_call_i     taken branch is a call (push br_pc_i + 1)
//   br_ret_i      taken branch is a return (pop link address)
//   br_pc_i       address of the resolving branch
//   br_target_i   taken target (unused when a return finds a link)
//   pc_o          current fetch address
//   fetch_valid_o pc_o is a real fetch, not a bubble
//   flush_o       one-cycle squash pulse, coincident with the redirect address
//   ras_ovf_o     sticky: a push happened on a full stack
//   ras_unf_o     one-cycle pulse: a return found no link address
//
// All outputs are registered, so flush_o and ras_unf_o appear in the first
// cycle that pc_o shows the redirect address.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                FLUSH_CYC = 2,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              br_valid_i,
    input  logic              br_taken_i,
    input  logic              br_call_i,
    input  logic              br_ret_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (FLUSH_CYC < 1 || FLUSH_CYC > 3) begin : g_bad_flush_cyc
        $error("pc_sequencer: FLUSH_CYC must be in 1..3");
    end
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
    end

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              flush_q, flush_d;
    logic              unf_q, unf_d;
    logic [1:0]        fcnt_q, fcnt_d;

    // -------------------------------------------------------------------------
    // Redirect decode. Branch results are only honoured in RUN; during FLUSH
    // they come from squashed instructions.
    // -------------------------------------------------------------------------
    logic              redirect;
    logic              is_ret;
    logic              is_call;
    logic              link_avail;
    logic [ADDR_W-1:0] link_addr;
    logic [ADDR_W-1:0] link_pc;
    logic [ADDR_W-1:0] redir_addr;

    assign redirect   = (state_q == ST_RUN) && br_valid_i && br_taken_i;
    assign is_ret     = redirect && br_ret_i;
    // A return takes priority over a call when both are flagged.
    assign is_call    = redirect && br_call_i && !br_ret_i;
    assign link_pc    = br_pc_i + 1'b1;
    assign redir_addr = (is_ret && link_avail) ? link_addr : br_target_i;

`ifdef PC_SEQ_RAS_EN
    // -------------------------------------------------------------------------
    // Circular return-address stack. sp_q points at the next free slot;
    // cnt_q counts live entries and saturates at RAS_DEPTH so that a push on
    // a full stack simply overwrites the oldest entry.
    // -------------------------------------------------------------------------
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  top_idx;
    logic              ras_full;

    assign top_idx    = sp_q - 1'b1;
    assign ras_full   = (cnt_q == CNT_W'(RAS_DEPTH));
    assign link_avail = (cnt_q != '0);
    // Combinational read so the popped address is usable in the same cycle.
    assign link_addr  = ras_mem[top_idx];

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (is_call) begin
            sp_d = sp_q + 1'b1;
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (is_ret && link_avail) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: cnt_q == 0 marks every entry as dead.
    always_ff @(posedge clk) begin
        if (is_call) begin
            ras_mem[sp_q] <= link_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ras_ovf_o = ovf_q;
`else
    // -------------------------------------------------------------------------
    // Single link register. It stays valid after a return, so repeated
    // returns all go to the most recent call's link address.
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] link_q, link_d;
    logic              link_vld_q, link_vld_d;

    assign link_avail = link_vld_q;
    assign link_addr  = link_q;

    always_comb begin
        link_d     = link_q;
        link_vld_d = link_vld_q;
        if (is_call) begin
            link_d     = link_pc;
            link_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_q     <= '0;
            link_vld_q <= 1'b0;
        end else begin
            link_q     <= link_d;
            link_vld_q <= link_vld_d;
        end
    end

    assign ras_ovf_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            unf_q         <= 1'b0;
            fcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            unf_q         <= unf_d;
            fcnt_q        <= fcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect) state_d = ST_FLUSH;
            ST_FLUSH: if (fcnt_q == FLUSH_LAST) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        unf_d         = 1'b0;
        fcnt_d        = fcnt_q;
        case (state_q)
            ST_BOOT: begin
                fetch_valid_d = 1'b0;
            end
            ST_RUN: begin
                if (redirect) begin
                    // A redirect overrides stall.
                    pc_d          = redir_addr;
                    fetch_valid_d = 1'b0;
                    flush_d       = 1'b1;
                    unf_d         = is_ret && !link_avail;
                    fcnt_d        = '0;
                end else if (!stall_i) begin
                    // The first RUN cycle after BOOT presents RESET_PC as a
                    // valid fetch; the PC only advances past a valid fetch.
                    if (fetch_valid_q) begin
                        pc_d = pc_q + 1'b1;
                    end
                    fetch_valid_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Stall does not stretch the bubble.
                if (fcnt_q == FLUSH_LAST) begin
                    fetch_valid_d = 1'b1;
                end else begin
                    fetch_valid_d = 1'b0;
                    fcnt_d        = fcnt_q + 1'b1;
                end
            end
            default: begin
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign flush_o       = flush_q;
    assign ras_unf_o     = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Each test queues per-cycle stimulus together with the expected registered
// outputs after the following rising edge, then drains the queues, comparing
// the DUT outputs 1 time unit after each edge. Expectations follow the
// stack or link-register behaviour depending on PC_SEQ_RAS_EN.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0100;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic        fv;
        logic        fl;
        logic        unf;
        logic        ovf;
    } obs_t;

    typedef struct packed {
        logic        stall;
        logic        bv;
        logic        bt;
        logic        call;
        logic        ret;
        logic [15:0] bpc;
        logic [15:0] tgt;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        br_call;
    logic        br_ret;
    logic [15:0] br_pc;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        ras_ovf;
    logic        ras_unf;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    total;
    int    passed;
    logic  ovf_exp;

    pc_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (RST_PC),
        .FLUSH_CYC(2),
        .RAS_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .br_valid_i   (br_valid),
        .br_taken_i   (br_taken),
        .br_call_i    (br_call),
        .br_ret_i     (br_ret),
        .br_pc_i      (br_pc),
        .br_target_i  (br_target),
        .pc_o         (pc),
        .fetch_valid_o(fetch_valid),
        .flush_o      (flush),
        .ras_ovf_o    (ras_ovf),
        .ras_unf_o    (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic s, input logic bv, input logic bt,
                                 input logic c, input logic r,
                                 input logic [15:0] bpc, input logic [15:0] tgt);
        st = '{stall: s, bv: bv, bt: bt, call: c, ret: r, bpc: bpc, tgt: tgt};
    endfunction

    function automatic obs_t ob(input logic [15:0] p, input logic fv, input logic fl,
                                input logic unf, input logic ovf);
        ob = '{pc: p, fv: fv, fl: fl, unf: unf, ovf: ovf};
    endfunction

    function automatic obs_t sample();
        sample = '{pc: pc, fv: fetch_valid, fl: flush, unf: ras_unf, ovf: ras_ovf};
    endfunction

    task automatic add(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic s, input obs_t e);
        add(st(s, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0), e);
    endtask

    // Drive one cycle of stimulus and advance to 1 unit past the next edge.
    task automatic tick(input stim_t s);
        stall     = s.stall;
        br_valid  = s.bv;
        br_taken  = s.bt;
        br_call   = s.call;
        br_ret    = s.ret;
        br_pc     = s.bpc;
        br_target = s.tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        rst_n = 1'b0;
        tick(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
        tick(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
        e   = ob(RST_PC, 1'b0, 1'b0, 1'b0, 1'b0);
        got = sample();
        total++;
        if (got !== e)
            $display("FAIL reset: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                     got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
        else
            passed++;
        $display("reset: pc=%h fv=%b", got.pc, got.fv);
    endtask

    task automatic test_boot();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        rst_n = 1'b1;
        idle(1'b0, ob(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0101, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0102, 1'b1, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL boot[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("boot[%0d]: pc=%h fv=%b", n, got.pc, got.fv);
            n++;
        end
    endtask

    task automatic test_run_stall();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        idle(1'b1, ob(16'h0102, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b1, ob(16'h0102, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0103, 1'b1, 1'b0, 1'b0, 1'b0));
        // Not-taken branches fall through, with and without stall.
        add(st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0103, 16'h0999), ob(16'h0104, 1'b1, 1'b0, 1'b0, 1'b0));
        add(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0104, 16'h0999), ob(16'h0104, 1'b1, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL run_stall[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("run_stall[%0d]: pc=%h fv=%b fl=%b", n, got.pc, got.fv, got.fl);
            n++;
        end
    endtask

    task automatic test_branch_stall();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        add(st(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0104, 16'h0040), ob(16'h0040, 1'b0, 1'b1, 1'b0, 1'b0));
        idle(1'b1, ob(16'h0040, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(1'b1, ob(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b1, ob(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0041, 1'b1, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL branch_stall[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("branch_stall[%0d]: pc=%h fv=%b fl=%b", n, got.pc, got.fv, got.fl);
            n++;
        end
    endtask

    task automatic test_call_return();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        add(st(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0200), ob(16'h0200, 1'b0, 1'b1, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0200, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0200, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0201, 1'b1, 1'b0, 1'b0, 1'b0));
        add(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0201, 16'hBEEF), ob(16'h0011, 1'b0, 1'b1, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0011, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(16'h0011, 1'b1, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL call_return[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("call_return[%0d]: pc=%h fv=%b fl=%b unf=%b", n, got.pc, got.fv, got.fl, got.unf);
            n++;
        end
    endtask

    task automatic test_nested_calls();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        logic [15:0] want;
        logic unf;
        for (int i = 0; i < 5; i++) begin
            if (RAS && i == 4) ovf_exp = 1'b1;
            add(st(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'(16'h0020 + i), 16'(16'h0300 + i)),
                ob(16'(16'h0300 + i), 1'b0, 1'b1, 1'b0, ovf_exp));
            idle(1'b0, ob(16'(16'h0300 + i), 1'b0, 1'b0, 1'b0, ovf_exp));
            idle(1'b0, ob(16'(16'h0300 + i), 1'b1, 1'b0, 1'b0, ovf_exp));
        end
        for (int i = 0; i < 5; i++) begin
            if (RAS)
                want = (i < 4) ? 16'(16'h0025 - i) : 16'(16'h0A00 + i);
            else
                want = 16'h0025;
            unf = RAS && (i == 4);
            add(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'(16'h0A00 + i)),
                ob(want, 1'b0, 1'b1, unf, ovf_exp));
            idle(1'b0, ob(want, 1'b0, 1'b0, 1'b0, ovf_exp));
            idle(1'b0, ob(want, 1'b1, 1'b0, 1'b0, ovf_exp));
        end
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL nested[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("nested[%0d]: pc=%h fv=%b fl=%b unf=%b ovf=%b", n, got.pc, got.fv, got.fl, got.unf, got.ovf);
            n++;
        end
    endtask

    task automatic test_flush_ignore();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        add(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0026, 16'h0500), ob(16'h0500, 1'b0, 1'b1, 1'b0, ovf_exp));
        // Taken call presented during FLUSH must be ignored entirely.
        add(st(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0600), ob(16'h0500, 1'b0, 1'b0, 1'b0, ovf_exp));
        add(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0600), ob(16'h0500, 1'b1, 1'b0, 1'b0, ovf_exp));
        idle(1'b0, ob(16'h0501, 1'b1, 1'b0, 1'b0, ovf_exp));
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL flush_ignore[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("flush_ignore[%0d]: pc=%h fv=%b fl=%b", n, got.pc, got.fv, got.fl);
            n++;
        end
    endtask

    task automatic test_reset_mid_flush();
        obs_t got;
        obs_t e;
        stim_t s;
        int n;
        // Call into FLUSH so the stack/link holds a fresh entry.
        s = st(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0060, 16'h0700);
        e = ob(16'h0700, 1'b0, 1'b1, 1'b0, ovf_exp);
        tick(s);
        got = sample();
        total++;
        if (got !== e)
            $display("FAIL rst_flush_enter: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                     got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
        else
            passed++;
        $display("rst_flush_enter: pc=%h fl=%b", got.pc, got.fl);
        // Asynchronous assertion mid-cycle: outputs must change without a clock.
        stall    = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        br_call  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        ovf_exp = 1'b0;
        e   = ob(RST_PC, 1'b0, 1'b0, 1'b0, 1'b0);
        got = sample();
        total++;
        if (got !== e)
            $display("FAIL rst_async: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                     got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
        else
            passed++;
        $display("rst_async: pc=%h fv=%b ovf=%b", got.pc, got.fv, got.ovf);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0, ob(RST_PC, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(1'b0, ob(RST_PC, 1'b1, 1'b0, 1'b0, 1'b0));
        // Stack/link was discarded, so this return must fall back to br_target.
        add(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0BAD), ob(16'h0BAD, 1'b0, 1'b1, 1'b1, 1'b0));
        idle(1'b0, ob(16'h0BAD, 1'b0, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            tick(s);
            got = sample();
            total++;
            if (got !== e)
                $display("FAIL rst_after[%0d]: got pc=%h fv=%b fl=%b unf=%b ovf=%b, want pc=%h fv=%b fl=%b unf=%b ovf=%b",
                         n, got.pc, got.fv, got.fl, got.unf, got.ovf, e.pc, e.fv, e.fl, e.unf, e.ovf);
            else
                passed++;
            $display("rst_after[%0d]: pc=%h fv=%b fl=%b unf=%b", n, got.pc, got.fv, got.fl, got.unf);
            n++;
        end
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        ovf_exp   = 1'b0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_call   = 1'b0;
        br_ret    = 1'b0;
        br_pc     = 16'h0;
        br_target = 16'h0;
        test_reset();
        test_boot();
        test_run_stall();
        test_branch_stall();
        test_call_return();
        test_nested_calls();
        test_flush_ignore();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks, want completion", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
